// File: rtl/patp_pkg.sv
// Shared PATP control types: ISA opcodes, ALU function codes and sequencer states.
package patp_pkg;

    typedef enum logic [2:0] {
        OP_HALT = 3'd0,
        OP_LDA  = 3'd1,
        OP_STA  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_JMP  = 3'd5,
        OP_JZ   = 3'd6,
        OP_OUT  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS_B = 2'd0,
        ALU_ADD    = 2'd1,
        ALU_SUB    = 2'd2
    } alu_fn_t;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_DEC  = 4'd4,
        ST_E0   = 4'd5,
        ST_E1   = 4'd6,
        ST_E2   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

endpackage

// File: rtl/patp_opdec.sv
// Combinational opcode classifier for the PATP control sequencer.
module patp_opdec
    import patp_pkg::*;
(
    input  opcode_t    op,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_alu,
    output logic       is_branch,
    output alu_fn_t    alu_fn
);

    always_comb begin
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_alu    = 1'b0;
        is_branch = 1'b0;
        alu_fn    = ALU_PASS_B;
        case (op)
            OP_LDA: begin
                is_mem = 1'b1;
                is_alu = 1'b1;
            end
            OP_STA: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_ADD: begin
                is_mem = 1'b1;
                is_alu = 1'b1;
                alu_fn = ALU_ADD;
            end
            OP_SUB: begin
                is_mem = 1'b1;
                is_alu = 1'b1;
                alu_fn = ALU_SUB;
            end
            OP_JMP,
            OP_JZ:   is_branch = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/patp_ctrl.sv
// PATP control sequencer: Moore FSM issuing fetch/decode/execute strobes to the datapath.
module patp_ctrl
    import patp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mar_sel,
    output logic       ld_mar,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       clk_alureg,
    output logic       ld_out,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] alu_fn,
    output logic       halted,
    output logic       busy
);

    state_t  state;
    state_t  state_nxt;
    opcode_t op_q;

    logic    is_mem;
    logic    is_store;
    logic    is_alu;
    logic    is_branch;
    alu_fn_t dec_fn;

    // Only the opcode field is consumed here; the address field feeds the MAR mux elsewhere.
    logic    unused_ir_addr;
    assign unused_ir_addr = ^ir[4:0];

    patp_opdec u_opdec (
        .op        (op_q),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .is_alu    (is_alu),
        .is_branch (is_branch),
        .alu_fn    (dec_fn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= OP_HALT;
        end else begin
            state <= state_nxt;
            if (state == ST_DEC) begin
                op_q <= opcode_t'(ir[7:5]);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE,
            ST_HALT: if (run) state_nxt = ST_F0;
            ST_F0:   state_nxt = ST_F1;
            ST_F1:   if (mem_ready) state_nxt = ST_F2;
            ST_F2:   state_nxt = ST_DEC;
            // DEC branches on the live IR because op_q only updates on this edge.
            ST_DEC:  state_nxt = (opcode_t'(ir[7:5]) == OP_HALT) ? ST_HALT : ST_E0;
            ST_E0:   state_nxt = is_mem ? ST_E1 : ST_F0;
            ST_E1:   if (mem_ready) state_nxt = is_store ? ST_F0 : ST_E2;
            ST_E2:   state_nxt = ST_F0;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mar_sel    = 1'b0;
        ld_mar     = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        clk_alureg = 1'b0;
        ld_out     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_fn     = 2'd0;
        halted     = (state == ST_HALT);
        busy       = (state != ST_IDLE) && (state != ST_HALT);
        case (state)
            ST_F0: ld_mar = 1'b1;
            ST_F1: mem_rd = 1'b1;
            ST_F2: begin
                ld_ir  = 1'b1;
                inc_pc = 1'b1;
            end
            ST_E0: begin
                if (is_mem) begin
                    ld_mar  = 1'b1;
                    mar_sel = 1'b1;
                end else if (is_branch) begin
                    ld_pc = (op_q == OP_JMP) || zero;
                end else if (op_q == OP_OUT) begin
                    ld_out = 1'b1;
                end
            end
            ST_E1: begin
                if (is_store) begin
                    mem_wr = 1'b1;
                end else if (is_alu) begin
                    mem_rd = 1'b1;
                end
            end
            ST_E2: begin
                clk_alureg = is_alu;
                alu_fn     = is_alu ? dec_fn : ALU_PASS_B;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_patp_ctrl.sv
// Directed bench for patp_ctrl: a per-instruction phase model builds the expected cycle trace.
module tb_patp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] ir = 8'h00;

    logic       mar_sel, ld_mar, ld_ir, inc_pc, ld_pc, clk_alureg, ld_out;
    logic       mem_rd, mem_wr, halted, busy;
    logic [1:0] alu_fn;

    always #5 clk = ~clk;

    patp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir         (ir),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mar_sel    (mar_sel),
        .ld_mar     (ld_mar),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .clk_alureg (clk_alureg),
        .ld_out     (ld_out),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .alu_fn     (alu_fn),
        .halted     (halted),
        .busy       (busy)
    );

    // Output word: {mar_sel, ld_mar, ld_ir, inc_pc, ld_pc, clk_alureg, ld_out, mem_rd, mem_wr, alu_fn, halted, busy}
    localparam logic [12:0] E_BUSY   = 13'h0001;
    localparam logic [12:0] E_HALTED = 13'h0002;
    localparam logic [12:0] E_WR     = 13'h0010;
    localparam logic [12:0] E_RD     = 13'h0020;
    localparam logic [12:0] E_OUT    = 13'h0040;
    localparam logic [12:0] E_ALUREG = 13'h0080;
    localparam logic [12:0] E_LDPC   = 13'h0100;
    localparam logic [12:0] E_INC    = 13'h0200;
    localparam logic [12:0] E_LDIR   = 13'h0400;
    localparam logic [12:0] E_LDMAR  = 13'h0800;
    localparam logic [12:0] E_MARSEL = 13'h1000;

    typedef struct {
        logic        rst;
        logic        run;
        logic        zero;
        logic        rdy;
        logic [7:0]  ir;
        logic [12:0] exp;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic push(input logic r, input logic rn, input logic z, input logic rdy,
                        input logic [7:0] i, input logic [12:0] e);
        ent_t t;
        t.rst = r; t.run = rn; t.zero = z; t.rdy = rdy; t.ir = i; t.exp = e;
        q.push_back(t);
    endtask

    // IR carries a different opcode everywhere except DEC; run is held high while busy.
    task automatic fetch(input logic [7:0] ins, input logic z, input int unsigned wf1);
        logic [7:0] junk;
        junk = ~ins;
        push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_LDMAR);
        for (int unsigned k = 0; k < wf1; k++) push(1'b0, 1'b1, z, 1'b0, junk, E_BUSY | E_RD);
        push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_RD);
        push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_LDIR | E_INC);
        push(1'b0, 1'b1, z, 1'b1, ins, E_BUSY);
    endtask

    task automatic instr(input logic [7:0] ins, input logic z,
                         input int unsigned wf1, input int unsigned we1);
        logic [7:0]  junk;
        logic [2:0]  op;
        logic [12:0] fn;
        junk = ~ins;
        op   = ins[7:5];
        fn   = (op == 3'd3) ? 13'h0004 : (op == 3'd4) ? 13'h0008 : 13'h0000;
        fetch(ins, z, wf1);
        case (op)
            3'd1, 3'd3, 3'd4: begin
                push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_LDMAR | E_MARSEL);
                for (int unsigned k = 0; k < we1; k++) push(1'b0, 1'b1, z, 1'b0, junk, E_BUSY | E_RD);
                push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_RD);
                push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_ALUREG | fn);
            end
            3'd2: begin
                push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_LDMAR | E_MARSEL);
                for (int unsigned k = 0; k < we1; k++) push(1'b0, 1'b1, z, 1'b0, junk, E_BUSY | E_WR);
                push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_WR);
            end
            3'd5: push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_LDPC);
            3'd6: push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | (z ? E_LDPC : 13'h0000));
            3'd7: push(1'b0, 1'b1, z, 1'b1, junk, E_BUSY | E_OUT);
            default: ;
        endcase
    endtask

    initial begin
        ent_t        e;
        logic [12:0] obs;
        int          cyc = 0;
        int          first_f0 = -1;
        int          first_alu = -1;
        int          n_alureg = 0, n_ldpc = 0, n_wr = 0, n_out = 0, n_halt = 0, n_fn_leak = 0;

        push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 13'h0000);
        push(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 13'h0000);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 13'h0000);
        push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 13'h0000);
        instr(8'h21, 1'b1, 0, 0);
        instr(8'h45, 1'b1, 0, 3);
        instr(8'hC3, 1'b1, 0, 0);
        instr(8'hC3, 1'b0, 0, 0);
        instr(8'h62, 1'b1, 1, 0);
        instr(8'h82, 1'b1, 0, 0);
        instr(8'hA0, 1'b1, 0, 0);
        instr(8'hE7, 1'b1, 0, 0);
        instr(8'h00, 1'b1, 0, 0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, E_HALTED);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, E_HALTED);
        push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, E_HALTED);
        // LDA aborted by reset while its operand read is pending
        fetch(8'h21, 1'b1, 0);
        push(1'b0, 1'b1, 1'b1, 1'b1, 8'hDE, E_BUSY | E_LDMAR | E_MARSEL);
        push(1'b0, 1'b1, 1'b1, 1'b0, 8'hDE, E_BUSY | E_RD);
        push(1'b1, 1'b1, 1'b1, 1'b1, 8'hDE, 13'h0000);
        push(1'b1, 1'b0, 1'b1, 1'b1, 8'hDE, 13'h0000);
        for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 13'h0000);
        push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 13'h0000);
        instr(8'hE1, 1'b1, 0, 0);
        instr(8'h00, 1'b1, 0, 0);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, E_HALTED);
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, E_HALTED);

        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; run = e.run; zero = e.zero; mem_ready = e.rdy; ir = e.ir;
            #1;
            obs = {mar_sel, ld_mar, ld_ir, inc_pc, ld_pc, clk_alureg, ld_out,
                   mem_rd, mem_wr, alu_fn, halted, busy};
            total++;
            if (obs !== e.exp) begin
                bad++;
                $display("FAIL cycle%0d outputs: got=%h want=%h", cyc, obs, e.exp);
            end
            if (ld_mar && first_f0 < 0) first_f0 = cyc;
            if (clk_alureg && first_alu < 0) first_alu = cyc;
            if (clk_alureg) n_alureg++;
            if (ld_pc) n_ldpc++;
            if (mem_wr) n_wr++;
            if (ld_out) n_out++;
            if (halted) n_halt++;
            if (alu_fn != 2'd0 && !clk_alureg) n_fn_leak++;
            cyc++;
        end

        total++;
        if (first_alu - first_f0 != 6) begin
            bad++;
            $display("FAIL lda_latency: got=%0d want=6", first_alu - first_f0);
        end
        total++;
        if (n_alureg != 3) begin bad++; $display("FAIL alureg_pulses: got=%0d want=3", n_alureg); end
        total++;
        if (n_ldpc != 2) begin bad++; $display("FAIL ldpc_pulses: got=%0d want=2", n_ldpc); end
        total++;
        if (n_wr != 4) begin bad++; $display("FAIL memwr_cycles: got=%0d want=4", n_wr); end
        total++;
        if (n_out != 2) begin bad++; $display("FAIL ldout_pulses: got=%0d want=2", n_out); end
        total++;
        if (n_halt != 5) begin bad++; $display("FAIL halted_cycles: got=%0d want=5", n_halt); end
        total++;
        if (n_fn_leak != 0) begin bad++; $display("FAIL alufn_leak: got=%0d want=0", n_fn_leak); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/patp_ctrl.md
# patp_ctrl

Control sequencer for the PATP core: a Moore FSM that fetches each instruction, decodes its opcode and drives the single-cycle load and enable strobes that other datapath blocks consume. These blocks include the ALU result register (`clk_alureg`), PC, MAR, IR, memory and output port. It is the issuing end of the strobe interface whose receiving end is the datapath registers. It sits between the instruction register and memory handshake on one side and every datapath load enable on the other.

## Interface
- No parameters; widths fixed by the 8-bit PATP ISA: opcode `ir[7:5]`, address `ir[4:0]`.
- `clk` in, 1: core clock, rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `run` in, 1: start or resume request, level-sampled in IDLE and HALT.
- `ir` in, 8: current IR contents; opcode sampled in DEC.
- `zero` in, 1: ALU-register-zero flag, sampled in E0 for JZ.
- `mem_ready` in, 1: memory completion, sampled only while `mem_rd` or `mem_wr` is high.
- `mar_sel` out, 1: MAR source select; 0 selects PC, 1 selects `ir[4:0]`.
- `ld_mar`, `ld_ir`, `inc_pc`, `ld_pc`, `clk_alureg`, `ld_out` out, 1 each: one-cycle load strobes.
- `mem_rd`, `mem_wr` out, 1 each: memory request, held until `mem_ready`.
- `alu_fn` out, 2: ALU function; 0 = PASS_B, 1 = ADD, 2 = SUB. Valid whenever `clk_alureg` is high; otherwise 0.
- `halted` out, 1: high in HALT.
- `busy` out, 1: high in any state other than IDLE and HALT.

## Operation
- Opcodes:
  - 000 HALT, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 OUT.
- States and transitions:
  - IDLE: goes to F0 when `run`=1.
  - F0: `ld_mar`=1, `mar_sel`=0. Goes to F1.
  - F1: `mem_rd`=1. Goes to F2 when `mem_ready`=1; otherwise stays in F1.
  - F2: `ld_ir`=1, `inc_pc`=1. Goes to DEC.
  - DEC: latches `ir[7:5]` into an internal opcode register. HALT goes to HALT; all other opcodes go to E0.
  - E0, LDA/STA/ADD/SUB: `ld_mar`=1, `mar_sel`=1. Goes to E1.
  - E0, JMP: `ld_pc`=1. Goes to F0.
  - E0, JZ: `ld_pc`=`zero`. Goes to F0.
  - E0, OUT: `ld_out`=1. Goes to F0.
  - E1, STA: `mem_wr`=1. Goes to F0 on `mem_ready`.
  - E1, LDA/ADD/SUB: `mem_rd`=1. Goes to E2 on `mem_ready`.
  - E2: `clk_alureg`=1 with `alu_fn` set to PASS_B for LDA, ADD for ADD, SUB for SUB. Goes to F0.
  - HALT: goes to F0 when `run`=1.
- Output rules:
  - All outputs decode from the state register and the latched opcode only (Moore).
  - No combinational path from `mem_ready`, `zero` or `ir` to any output. Sole exception: `ld_pc` in JZ/E0 is `zero` ANDed with the state.
  - Every strobe not listed for a state is 0.
- Boundary rules:
  - `mem_ready` high outside F1/E1 is ignored.
  - `mem_rd` and `mem_wr` are never high together.
  - `run` is ignored while `busy`.
  - An opcode change on `ir` after DEC has no effect.

## Timing
- Reset: async entry to IDLE; every output 0, including `halted` and `busy`. Opcode register clears to 000.
- Reset asserted mid-instruction: strobes drop in the same cycle. No partial E2 write occurs after `rst` rises.
- Cycles per instruction with `mem_ready` tied 1:
  - Fetch + decode: 4.
  - LDA/ADD/SUB: 7.
  - STA: 6.
  - JMP/JZ/OUT: 5.
  - HALT: 4, then `halted`=1.
- Each cycle of `mem_ready`=0 in F1 or E1 adds exactly one cycle. The request stays asserted throughout.
- All strobes are exactly one cycle wide, except `mem_rd`/`mem_wr`.

## Structure
- Package `patp_pkg` holds:
  - opcode enum (`OP_HALT` … `OP_OUT`);
  - ALU function enum (`ALU_PASS_B`, `ALU_ADD`, `ALU_SUB`);
  - state enum (IDLE, F0, F1, F2, DEC, E0, E1, E2, HALT).
- One sub-module, `patp_opdec`: combinational opcode-to-class decode producing `is_mem`, `is_store`, `is_alu`, `is_branch` and `alu_fn`.
- The FSM and output decode stay in `patp_ctrl`.

## Test plan
- Reset then `run`=1 with `ir`=8'h21 (LDA 1), `mem_ready`=1 -> strobe order `ld_mar`, `mem_rd`, `ld_ir`+`inc_pc`, DEC, `ld_mar`(`mar_sel`=1), `mem_rd`, then `clk_alureg` with `alu_fn`=0 on cycle 7; `busy` stays high throughout.
- STA (`ir`=8'h45) with `mem_ready` low for 3 cycles in E1 -> `mem_wr` held 4 cycles and dropped after `mem_ready` is sampled; instruction takes 9 cycles.
- JZ (`ir`=8'hC3) run twice, with `zero`=1 and then `zero`=0 -> `ld_pc` pulses once in E0 for the first run and never for the second; both return to F0 after 5 cycles.
- ADD (8'h62) then SUB (8'h82) -> `clk_alureg` pulses with `alu_fn`=1, then with `alu_fn`=2, and never with `alu_fn` nonzero outside E2.
- HALT (8'h00) -> `halted`=1 and `busy`=0 after 4 cycles; `run` pulse -> F0 with `ld_mar`=1 next cycle.
- `rst` asserted during E1 of LDA with `mem_rd` high -> all outputs 0 immediately; after release, state is IDLE and no `clk_alureg` pulse occurs.
